bus_sequencer: RTL and testbench

Owns the single external memory bus and shares it between instruction fetch and the memory stage (LOAD/STORE issued by memorystage1).
- Sequences each bus cycle: grant, drive, wait for ready, capture, complete.
- Generates byte strobes, lane steering and alignment checks from the cycle width.
- Sits between the fetch/memory stages and the top-level bus pins.

---
 rtl/bus_sequencer_pkg.sv | 19 +
 rtl/bus_sequencer_if.sv | 25 ++
 rtl/bus_sequencer_lane_steer.sv | 44 ++++
 rtl/bus_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_bus_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_sequencer_pkg.sv
// Shared opcode constants and bus-interface types for the bus sequencer.
// Timeout support is selected with BUS_SEQUENCER_TIMEOUT_EN.
package opcodes;
  localparam logic [4:0] OPCODE_NOP = 5'h01;
endpackage

package businterface;
  typedef enum logic [1:0] {
    CW_BYTE = 2'd0,
    CW_HALF = 2'd1,
    CW_WORD = 2'd2
  } t_cycle_width;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_MEM   = 2'd2
  } t_bus_state;
endpackage

// File: rtl/bus_sequencer_if.sv
// External memory bus pins shared between the sequencer and a slave.
// The sequencer drives the master side; a memory or bench drives the slave side.
interface bus_sequencer_if #(
  parameter int ADDR_WIDTH = 30
);
  logic [ADDR_WIDTH-1:0] bus_address;
  logic [31:0]           bus_data_out;
  logic [31:0]           bus_data_in;
  logic                  bus_read;
  logic                  bus_write;
  logic [3:0]            bus_strobes;
  logic                  bus_ready;

  modport master (
    output bus_address, bus_data_out,
    output bus_read, bus_write, bus_strobes,
    input  bus_data_in, bus_ready
  );

  modport slave (
    input  bus_address, bus_data_out,
    input  bus_read, bus_write, bus_strobes,
    output bus_data_in, bus_ready
  );
endinterface

// File: rtl/bus_sequencer_lane_steer.sv
// Big-endian lane steering: strobes, replicated write data, aligned read data.
// Purely combinational so other bus masters can reuse it.
import businterface::*;

module bus_lane_steer (
  input  logic [1:0]  width_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  strobes_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);
  logic [31:0] shifted;

  always_comb begin
    strobes_o    = 4'b0000;
    wdata_o      = wdata_i;
    rdata_o      = rdata_i;
    misaligned_o = 1'b0;
    // byte lane 3 holds address offset 0, so shift by (3 - a) bytes
    shifted      = rdata_i >> {~addr_i, 3'b000};
    case (width_i)
      CW_BYTE: begin
        strobes_o = 4'b1000 >> addr_i;
        wdata_o   = {4{wdata_i[7:0]}};
        rdata_o   = {24'h0, shifted[7:0]};
      end
      CW_HALF: begin
        strobes_o    = addr_i[1] ? 4'b0011 : 4'b1100;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = {16'h0, addr_i[1] ? rdata_i[15:0]
                                         : rdata_i[31:16]};
        misaligned_o = addr_i[0];
      end
      CW_WORD: begin
        strobes_o    = 4'b1111;
        misaligned_o = |addr_i;
      end
      default: misaligned_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/bus_sequencer.sv
// Single external bus owner arbitrating fetch and memory-stage cycles.
// Define BUS_SEQUENCER_TIMEOUT_EN to abort cycles stuck without bus_ready.
import businterface::*;
import opcodes::*;

module bus_sequencer #(
  parameter int ADDR_WIDTH     = 30,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_done,
  output logic        fetch_stall,
  input  logic        mem_req,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_width,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_done,
  output logic        mem_error,
  bus_sequencer_if.master bus
);
  t_bus_state            state_q, state_d;
  logic [1:0]            width_q, width_d;
  logic [1:0]            a_q, a_d;
  logic                  reject_q, reject_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           dout_q, dout_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [3:0]            stb_q, stb_d;
  logic [31:0]           fdata_q, fdata_d;
  logic                  fdone_q, fdone_d;
  logic                  stall_q, stall_d;
  logic [31:0]           mdata_q, mdata_d;
  logic                  mdone_q, mdone_d;
  logic                  merr_q, merr_d;
  logic                  fin, abort;
  logic                  idle;
  logic [1:0]            s_width, s_addr;
  logic [3:0]            s_stb;
  logic [31:0]           s_wdata, s_rdata;
  logic                  s_mis;
`ifdef BUS_SEQUENCER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wait_q, wait_d;
`endif

  assign idle    = (state_q == ST_IDLE);
  assign s_width = idle ? mem_width : width_q;
  assign s_addr  = idle ? mem_address[1:0] : a_q;

  bus_lane_steer u_steer (
    .width_i      (s_width),
    .addr_i       (s_addr),
    .wdata_i      (mem_write_data),
    .rdata_i      (bus.bus_data_in),
    .strobes_o    (s_stb),
    .wdata_o      (s_wdata),
    .rdata_o      (s_rdata),
    .misaligned_o (s_mis)
  );

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    a_d      = a_q;
    reject_d = reject_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    stb_d    = stb_q;
    fdata_d  = fdata_q;
    fdone_d  = 1'b0;
    mdata_d  = mdata_q;
    mdone_d  = 1'b0;
    merr_d   = 1'b0;
    stall_d  = mem_req | (state_q == ST_MEM);
    fin      = 1'b0;
    abort    = 1'b0;
`ifdef BUS_SEQUENCER_TIMEOUT_EN
    wait_d   = wait_q;
`endif
    unique case (1'b1)
      idle: begin
`ifdef BUS_SEQUENCER_TIMEOUT_EN
        wait_d = '0;
`endif
        if (mem_req) begin
          state_d  = ST_MEM;
          width_d  = mem_width;
          a_d      = mem_address[1:0];
          reject_d = s_mis | (mem_read == mem_write);
          if (!reject_d) begin
            addr_d = mem_address[ADDR_WIDTH+1:2];
            dout_d = s_wdata;
            rd_d   = mem_read;
            wr_d   = mem_write;
            stb_d  = s_stb;
          end
        end else if (fetch_req) begin
          state_d  = ST_FETCH;
          width_d  = CW_WORD;
          a_d      = fetch_address[1:0];
          reject_d = 1'b0;
          addr_d   = fetch_address[ADDR_WIDTH+1:2];
          rd_d     = 1'b1;
          stb_d    = 4'b1111;
        end
      end
      default: begin
        // a rejected request finishes one edge later without a bus cycle
        if (state_q == ST_MEM && reject_q) begin
          fin   = 1'b1;
          abort = 1'b1;
        end else if (bus.bus_ready) begin
          fin = 1'b1;
        end
`ifdef BUS_SEQUENCER_TIMEOUT_EN
        else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
          fin   = 1'b1;
          abort = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
`endif
      end
    endcase

    if (fin) begin
      state_d = ST_IDLE;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      stb_d   = 4'b0000;
      if (state_q == ST_FETCH) begin
        fdone_d = 1'b1;
        fdata_d = abort ? {OPCODE_NOP, 27'h0} : bus.bus_data_in;
      end else begin
        mdone_d = 1'b1;
        merr_d  = abort;
        if (abort)     mdata_d = '0;
        else if (rd_q) mdata_d = s_rdata;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      width_q  <= 2'b00;
      a_q      <= 2'b00;
      reject_q <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      stb_q    <= 4'b0000;
      fdata_q  <= '0;
      fdone_q  <= 1'b0;
      stall_q  <= 1'b0;
      mdata_q  <= '0;
      mdone_q  <= 1'b0;
      merr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      a_q      <= a_d;
      reject_q <= reject_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      stb_q    <= stb_d;
      fdata_q  <= fdata_d;
      fdone_q  <= fdone_d;
      stall_q  <= stall_d;
      mdata_q  <= mdata_d;
      mdone_q  <= mdone_d;
      merr_q   <= merr_d;
    end
  end

`ifdef BUS_SEQUENCER_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`endif

  assign bus.bus_address  = addr_q;
  assign bus.bus_data_out = dout_q;
  assign bus.bus_read     = rd_q;
  assign bus.bus_write    = wr_q;
  assign bus.bus_strobes  = stb_q;
  assign fetch_data       = fdata_q;
  assign fetch_done       = fdone_q;
  assign fetch_stall      = stall_q;
  assign mem_read_data    = mdata_q;
  assign mem_done         = mdone_q;
  assign mem_error        = merr_q;
endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer; timeout steps run when
// BUS_SEQUENCER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
import opcodes::*;

module tb_bus_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_address = '0;
  logic [31:0] fetch_data;
  logic        fetch_done, fetch_stall;
  logic        mem_req = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [1:0]  mem_width = 2'd0;
  logic [31:0] mem_address = '0, mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        mem_done, mem_error;
  int          n_cmp = 0;
  int          n_err = 0;

  bus_sequencer_if #(.ADDR_WIDTH(30)) bus ();

  bus_sequencer #(.ADDR_WIDTH(30), .TIMEOUT_CYCLES(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_req      (fetch_req),
    .fetch_address  (fetch_address),
    .fetch_data     (fetch_data),
    .fetch_done     (fetch_done),
    .fetch_stall    (fetch_stall),
    .mem_req        (mem_req),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_width      (mem_width),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_done       (mem_done),
    .mem_error      (mem_error),
    .bus            (bus)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.bus_ready   = 1'b0;
    bus.bus_data_in = '0;
    cyc();
    cyc();
    chk("rst_read", {31'h0, bus.bus_read}, 0);
    chk("rst_write", {31'h0, bus.bus_write}, 0);
    chk("rst_strobes", {28'h0, bus.bus_strobes}, 0);
    chk("rst_addr", {2'b0, bus.bus_address}, 0);
    chk("rst_dones", {29'h0, fetch_done, mem_done, mem_error}, 0);
    chk("rst_stall", {31'h0, fetch_stall}, 0);
    reset = 1'b0;
    cyc();

    // fetch only, zero wait states
    fetch_req = 1'b1;
    fetch_address = 32'h100;
    bus.bus_ready = 1'b1;
    bus.bus_data_in = 32'hDEADBEEF;
    cyc();
    chk("f1_addr", {2'b0, bus.bus_address}, 32'h40);
    chk("f1_stb", {28'h0, bus.bus_strobes}, 32'hF);
    chk("f1_read", {31'h0, bus.bus_read}, 1);
    chk("f1_early", {31'h0, fetch_done}, 0);
    cyc();
    chk("f1_done", {31'h0, fetch_done}, 1);
    chk("f1_data", fetch_data, 32'hDEADBEEF);
    chk("f1_rdrop", {31'h0, bus.bus_read}, 0);
    fetch_req = 1'b0;
    cyc();
    chk("f1_pulse", {31'h0, fetch_done}, 0);

    // memory byte read and fetch together: memory wins
    fetch_req = 1'b1;
    fetch_address = 32'h300;
    mem_req = 1'b1;
    mem_read = 1'b1;
    mem_write = 1'b0;
    mem_width = 2'd0;
    mem_address = 32'h203;
    bus.bus_data_in = 32'h11223344;
    cyc();
    chk("arb_stb", {28'h0, bus.bus_strobes}, 32'h1);
    chk("arb_addr", {2'b0, bus.bus_address}, 32'h80);
    chk("arb_stall", {31'h0, fetch_stall}, 1);
    cyc();
    chk("arb_mdone", {31'h0, mem_done}, 1);
    chk("arb_fdone", {31'h0, fetch_done}, 0);
    chk("arb_mdata", mem_read_data, 32'h44);
    chk("arb_merr", {31'h0, mem_error}, 0);
    chk("arb_stall2", {31'h0, fetch_stall}, 1);
    mem_req = 1'b0;
    cyc();
    chk("arb_fstb", {28'h0, bus.bus_strobes}, 32'hF);
    chk("arb_faddr", {2'b0, bus.bus_address}, 32'hC0);
    chk("arb_stall3", {31'h0, fetch_stall}, 0);
    cyc();
    chk("arb_fdone2", {31'h0, fetch_done}, 1);
    chk("arb_fdata", fetch_data, 32'h11223344);
    fetch_req = 1'b0;
    cyc();

    // half write with three wait states
    bus.bus_ready = 1'b0;
    mem_req = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b1;
    mem_width = 2'd1;
    mem_address = 32'h12345672;
    mem_write_data = 32'h0000ABCD;
    cyc();
    chk("hw_stb", {28'h0, bus.bus_strobes}, 32'h3);
    chk("hw_dout", bus.bus_data_out, 32'hABCDABCD);
    chk("hw_addr", {2'b0, bus.bus_address}, 32'h048D159C);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hw_hold", {30'h0, bus.bus_write, mem_done}, 32'h2);
    end
    bus.bus_ready = 1'b1;
    cyc();
    chk("hw_done", {30'h0, bus.bus_write, mem_done}, 32'h1);
    mem_req = 1'b0;
    cyc();
    chk("hw_pulse", {31'h0, mem_done}, 0);

    // misaligned word read is rejected
    mem_req = 1'b1;
    mem_read = 1'b1;
    mem_write = 1'b0;
    mem_width = 2'd2;
    mem_address = 32'h1002;
    cyc();
    chk("rj_nostb", {26'h0, bus.bus_read, bus.bus_write,
                     bus.bus_strobes}, 0);
    chk("rj_early", {31'h0, mem_done}, 0);
    cyc();
    chk("rj_done", {30'h0, mem_done, mem_error}, 32'h3);
    chk("rj_nostb2", {28'h0, bus.bus_strobes}, 0);
    mem_req = 1'b0;
    cyc();
    chk("rj_pulse", {31'h0, mem_error}, 0);

    // reset during a write wait state
    bus.bus_ready = 1'b0;
    mem_req = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b1;
    mem_width = 2'd2;
    mem_address = 32'h40;
    mem_write_data = 32'hCAFEF00D;
    cyc();
    chk("rs_write", {31'h0, bus.bus_write}, 1);
    chk("rs_dout", bus.bus_data_out, 32'hCAFEF00D);
    cyc();
    #2 reset = 1'b1;
    #1;
    chk("rs_drop", {27'h0, bus.bus_write, bus.bus_strobes}, 0);
    chk("rs_nodone", {31'h0, mem_done}, 0);
    mem_req = 1'b0;
    #2 reset = 1'b0;
    cyc();
    chk("rs_nodone2", {31'h0, mem_done}, 0);

    // normal half reads after reset
    bus.bus_ready = 1'b1;
    bus.bus_data_in = 32'h11223344;
    mem_req = 1'b1;
    mem_read = 1'b1;
    mem_write = 1'b0;
    mem_width = 2'd1;
    mem_address = 32'h202;
    cyc();
    chk("pr_stb", {28'h0, bus.bus_strobes}, 32'h3);
    cyc();
    chk("pr_done", {30'h0, mem_done, mem_error}, 32'h2);
    chk("pr_data", mem_read_data, 32'h3344);
    mem_req = 1'b0;
    cyc();
    mem_req = 1'b1;
    mem_address = 32'h200;
    cyc();
    chk("pr_stb2", {28'h0, bus.bus_strobes}, 32'hC);
    cyc();
    chk("pr_data2", mem_read_data, 32'h1122);
    mem_req = 1'b0;
    cyc();

`ifdef BUS_SEQUENCER_TIMEOUT_EN
    bus.bus_ready = 1'b0;
    mem_req = 1'b1;
    mem_width = 2'd2;
    mem_address = 32'h10;
    cyc();
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("to_wait", {30'h0, bus.bus_read, mem_done}, 32'h2);
    end
    cyc();
    chk("to_mdone", {30'h0, mem_done, mem_error}, 32'h3);
    chk("to_mdata", mem_read_data, 0);
    chk("to_mdrop", {31'h0, bus.bus_read}, 0);
    mem_req = 1'b0;
    cyc();
    fetch_req = 1'b1;
    fetch_address = 32'h20;
    cyc();
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("to_fwait", {31'h0, fetch_done}, 0);
    end
    cyc();
    chk("to_fdone", {31'h0, fetch_done}, 1);
    chk("to_fdata", fetch_data, {OPCODE_NOP, 27'h0});
    fetch_req = 1'b0;
    cyc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
